// File: rtl/e1b_chip_nco_pkg.sv
// e1b_chip_nco_pkg -- shared constants and helpers for the Galileo E1B code
// NCO and the shared E1B code memory that consumes its chip index.
//   E1B_CODELEN  : chips per code epoch (4092)
//   E1B_CODEBITS : chip index width
//   NCO_BITS     : phase accumulator / rate width
//   SLEW_BITS    : code-retard hold counter width
package e1b_chip_nco_pkg;

  localparam int E1B_CODELEN  = 4092;
  localparam int E1B_CODEBITS = 12;
  localparam int NCO_BITS     = 32;
  localparam int SLEW_BITS    = 16;

  localparam logic [E1B_CODEBITS-1:0] CHIP_ZERO = 12'd0;
  localparam logic [E1B_CODEBITS-1:0] CHIP_ONE  = 12'd1;
  localparam logic [E1B_CODEBITS-1:0] CHIP_LAST = 12'd4091;
  localparam logic [NCO_BITS-1:0]     ACC_ZERO  = 32'd0;
  localparam logic [SLEW_BITS-1:0]    HOLD_ZERO = 16'd0;
  localparam logic [SLEW_BITS-1:0]    HOLD_ONE  = 16'd1;

  // Chip index after one chip boundary, wrapping at the end of the epoch.
  function automatic logic [E1B_CODEBITS-1:0] next_chip(input logic [E1B_CODEBITS-1:0] chip);
    logic [E1B_CODEBITS-1:0] nxt;
    if (chip == CHIP_LAST) begin
      nxt = CHIP_ZERO;
    end else begin
      nxt = chip + CHIP_ONE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/e1b_chip_nco_if.sv
// e1b_chip_nco_if -- control/status bundle of one E1B code NCO channel.
//   master : CPU / channel controller side (drives rate, restart, slew)
//   slave  : NCO side (drives chip index, strobes, subcarrier, epoch count)
interface e1b_chip_nco_if;
  import e1b_chip_nco_pkg::*;

  logic                    rate_wr;
  logic [NCO_BITS-1:0]     rate_i;
  logic                    restart;
  logic                    slew_wr;
  logic [SLEW_BITS-1:0]    slew_i;
  logic [E1B_CODEBITS-1:0] nchip;
  logic                    full_chip;
  logic                    half_chip;
  logic                    sub_o;
  logic                    epoch;
  logic                    slewing;
  logic [15:0]             epoch_cnt;

  modport master (
    output rate_wr, rate_i, restart, slew_wr, slew_i,
    input  nchip, full_chip, half_chip, sub_o, epoch, slewing, epoch_cnt
  );

  modport slave (
    input  rate_wr, rate_i, restart, slew_wr, slew_i,
    output nchip, full_chip, half_chip, sub_o, epoch, slewing, epoch_cnt
  );
endinterface

// File: rtl/e1b_phase_acc.sv
// e1b_phase_acc -- code-phase accumulator with code-retard hold counter.
//   clk, rst_n      : clock, asynchronous active-low reset
//   rate_wr, rate_i : load phase increment (takes effect on the next add)
//   restart         : clear accumulator and hold counter
//   slew_wr, slew_i : freeze the phase for slew_i clocks (0 = ignored)
//   carry_o         : raw (unregistered) chip-boundary pulse of this cycle's add
//   half_o          : raw half-chip-boundary pulse (includes chip boundaries)
//   msb_o           : accumulator MSB, i.e. the BOC(1,1) subcarrier phase
//   slewing_o       : registered, high while the hold counter is nonzero
module e1b_phase_acc
  import e1b_chip_nco_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rate_wr,
  input  logic [NCO_BITS-1:0]  rate_i,
  input  logic                 restart,
  input  logic                 slew_wr,
  input  logic [SLEW_BITS-1:0] slew_i,
  output logic                 carry_o,
  output logic                 half_o,
  output logic                 msb_o,
  output logic                 slewing_o
);

  logic [NCO_BITS-1:0]  acc_q, acc_d;
  logic [NCO_BITS-1:0]  rate_q, rate_d;
  logic [SLEW_BITS-1:0] hold_q, hold_d;
  logic                 slewing_q, slewing_d;
  logic [NCO_BITS:0]    sum_s;
  logic                 carry_s, half_s;

  // Next-state: restart beats a slew load, which beats the hold countdown / add.
  always_comb begin
    acc_d   = acc_q;
    rate_d  = rate_q;
    hold_d  = hold_q;
    carry_s = 1'b0;
    half_s  = 1'b0;
    sum_s   = {1'b0, acc_q} + {1'b0, rate_q};

    if (rate_wr) begin
      rate_d = rate_i;
    end else begin
      rate_d = rate_q;
    end

    if (restart) begin
      acc_d  = ACC_ZERO;
      hold_d = HOLD_ZERO;
    end else if (slew_wr && (slew_i != HOLD_ZERO)) begin
      hold_d = slew_i;
    end else if (hold_q != HOLD_ZERO) begin
      hold_d = hold_q - HOLD_ONE;
    end else begin
      acc_d   = sum_s[NCO_BITS-1:0];
      carry_s = sum_s[NCO_BITS];
      // Rates are limited to 2^31, so a carry and an MSB 0->1 rise never
      // both happen in one add; either one is a half-chip boundary.
      half_s  = sum_s[NCO_BITS] | (~acc_q[NCO_BITS-1] & sum_s[NCO_BITS-1]);
    end

    slewing_d = (hold_d != HOLD_ZERO);
  end

  // Accumulator, rate, hold counter and slewing flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= ACC_ZERO;
      rate_q    <= ACC_ZERO;
      hold_q    <= HOLD_ZERO;
      slewing_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      rate_q    <= rate_d;
      hold_q    <= hold_d;
      slewing_q <= slewing_d;
    end
  end

  assign carry_o   = carry_s;
  assign half_o    = half_s;
  assign msb_o     = acc_q[NCO_BITS-1];
  assign slewing_o = slewing_q;

endmodule

// File: rtl/e1b_chip_nco.sv
// e1b_chip_nco -- per-channel Galileo E1B code-phase NCO.
//   clk   : sole clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : e1b_chip_nco_if.slave -- rate/restart/slew controls in; chip
//           index, full/half-chip strobes, subcarrier, epoch strobe,
//           slewing flag and epoch count out. All outputs are registered;
//           nchip and full_chip update on the same edge so the code memory
//           can prefetch the code bit for nchip+1.
// Optional build macro E1B_EPOCH_CNT_EN adds a 16-bit wrapping epoch counter
// (cleared by reset and restart); without it epoch_cnt is driven 0.
module e1b_chip_nco
  import e1b_chip_nco_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  e1b_chip_nco_if.slave bus
);

  logic                    carry_s, half_s, msb_s, slewing_s;
  logic [E1B_CODEBITS-1:0] nchip_q, nchip_d;
  logic                    full_chip_q, full_chip_d;
  logic                    half_chip_q, half_chip_d;
  logic                    epoch_q, epoch_d;

  e1b_phase_acc u_phase_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .rate_wr   (bus.rate_wr),
    .rate_i    (bus.rate_i),
    .restart   (bus.restart),
    .slew_wr   (bus.slew_wr),
    .slew_i    (bus.slew_i),
    .carry_o   (carry_s),
    .half_o    (half_s),
    .msb_o     (msb_s),
    .slewing_o (slewing_s)
  );

  // Chip counter and strobe next-state; the accumulator already suppresses
  // carry/half during restart and hold.
  always_comb begin
    nchip_d     = nchip_q;
    full_chip_d = 1'b0;
    half_chip_d = half_s;
    epoch_d     = 1'b0;
    if (bus.restart) begin
      nchip_d = CHIP_ZERO;
    end else if (carry_s) begin
      nchip_d     = next_chip(nchip_q);
      full_chip_d = 1'b1;
      epoch_d     = (nchip_q == CHIP_LAST);
    end else begin
      nchip_d = nchip_q;
    end
  end

  // Chip index and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nchip_q     <= CHIP_ZERO;
      full_chip_q <= 1'b0;
      half_chip_q <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      nchip_q     <= nchip_d;
      full_chip_q <= full_chip_d;
      half_chip_q <= half_chip_d;
      epoch_q     <= epoch_d;
    end
  end

`ifdef E1B_EPOCH_CNT_EN
  logic [15:0] epoch_cnt_q, epoch_cnt_d;

  // Epoch counter next-state: cleared by restart, counts each epoch wrap.
  always_comb begin
    epoch_cnt_d = epoch_cnt_q;
    if (bus.restart) begin
      epoch_cnt_d = 16'd0;
    end else if (epoch_d) begin
      epoch_cnt_d = epoch_cnt_q + 16'd1;
    end else begin
      epoch_cnt_d = epoch_cnt_q;
    end
  end

  // Epoch counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_cnt_q <= 16'd0;
    end else begin
      epoch_cnt_q <= epoch_cnt_d;
    end
  end

  assign bus.epoch_cnt = epoch_cnt_q;
`else
  assign bus.epoch_cnt = 16'd0;
`endif

  assign bus.nchip     = nchip_q;
  assign bus.full_chip = full_chip_q;
  assign bus.half_chip = half_chip_q;
  assign bus.epoch     = epoch_q;
  assign bus.sub_o     = msb_s;
  assign bus.slewing   = slewing_s;

endmodule
